// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Shares one iterative shift-add signed multiplier among NREQ
//               requesters. Arbitrates between requesters, latches the
//               winner's operands, clears and times the multiplier, then
//               returns the product through a valid/ready response port.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               req, a_in, b_in, gnt        - requester side
//               rsp_valid/ready/id/data     - response side
//               mul_rst, mul_a, mul_b,
//               mul_acc, mul_done           - multiplier side
// Config      : MUL_ARB_FIXED_PRIO_EN - when defined, fixed priority with the
//               lowest index winning; otherwise round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int N    = 5,
    parameter int M    = 6,
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*N-1:0]      a_in,
    input  logic [NREQ*M-1:0]      b_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N+M:0]           rsp_data,
    output logic                   mul_rst,
    output logic [N-1:0]           mul_a,
    output logic [M-1:0]           mul_b,
    input  logic [N+M:0]           mul_acc,
    input  logic                   mul_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = N + M + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state_q,     state_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [PW-1:0]   rsp_data_q,  rsp_data_d;
    logic            mul_rst_q,   mul_rst_d;
    logic [N-1:0]    mul_a_q,     mul_a_d;
    logic [M-1:0]    mul_b_q,     mul_b_d;

    // Arbitration results
    logic            w_lo_found;
    logic [IDW-1:0]  w_lo_idx;
    logic [IDW-1:0]  w_win;
    logic [N-1:0]    w_win_a;
    logic [M-1:0]    w_win_b;

`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            w_hi_found;
    logic [IDW-1:0]  w_hi_idx;
`endif

    // Winner search. The lowest active index is the fixed-priority winner.
    // For round-robin, the lowest active index above rr_ptr wins; if none
    // exists the search wraps and the lowest active index wins.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
`endif
        for (int j = 0; j < NREQ; j++) begin
            if (req[j]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = IDW'(j);
                end
`ifndef MUL_ARB_FIXED_PRIO_EN
                if (!w_hi_found && (j > int'(rr_ptr_q))) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDW'(j);
                end
`endif
            end
        end
`ifdef MUL_ARB_FIXED_PRIO_EN
        w_win = w_lo_idx;
`else
        w_win = w_hi_found ? w_hi_idx : w_lo_idx;
`endif
    end

    // Operand mux for the selected requester
    always_comb begin
        w_win_a = '0;
        w_win_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == IDW'(j)) begin
                w_win_a = a_in[j*N +: N];
                w_win_b = b_in[j*M +: M];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        mul_rst_d   = mul_rst_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
`ifndef MUL_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                mul_rst_d = 1'b1;
                if (|req) begin
                    gnt_d    = NREQ'(1) << w_win;
                    mul_a_d  = w_win_a;
                    mul_b_d  = w_win_b;
                    rsp_id_d = w_win;
`ifndef MUL_ARB_FIXED_PRIO_EN
                    rr_ptr_d = w_win;
`endif
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Multiplier is cleared at this edge; release it for RUN.
                mul_rst_d = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Capture on the first done edge: the multiplier keeps
                // accumulating afterwards, so later values are garbage.
                if (mul_done) begin
                    rsp_data_d  = mul_acc;
                    rsp_valid_d = 1'b1;
                    mul_rst_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                mul_rst_d = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                mul_rst_d = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            mul_rst_q   <= 1'b1;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            mul_rst_q   <= mul_rst_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign mul_rst   = mul_rst_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arbiter
// Description : Directed self-checking bench for mul_share_arbiter with a
//               behavioural shift-add signed multiplier attached.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    localparam int N    = 5;
    localparam int M    = 6;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int PW   = N + M + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_in;
    logic [NREQ*M-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_data;
    logic              mul_rst;
    logic [N-1:0]      mul_a;
    logic [M-1:0]      mul_b;
    logic [PW-1:0]     mul_acc;
    logic              mul_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_share_arbiter #(.N(N), .M(M), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .mul_rst   (mul_rst),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_acc   (mul_acc),
        .mul_done  (mul_done)
    );

    // Behavioural multiplier: M iterations, sticky done, keeps adding A
    // after done so a late capture yields a wrong product.
    int            m_i;
    logic [PW-1:0] m_ax;
    assign m_ax = {{(PW-N){mul_a[N-1]}}, mul_a};

    always @(posedge clk) begin
        if (mul_rst) begin
            m_i      <= 0;
            mul_acc  <= '0;
            mul_done <= 1'b0;
        end else if (m_i < M) begin
            if (mul_b[m_i]) begin
                if (m_i == M-1) mul_acc <= mul_acc - (m_ax << m_i);
                else            mul_acc <= mul_acc + (m_ax << m_i);
            end
            if (m_i == M-1) mul_done <= 1'b1;
            m_i <= m_i + 1;
        end else begin
            mul_acc <= mul_acc + m_ax;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, output logic [NREQ-1:0] g, output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (gnt === '0) begin
            total++;
            bad++;
            $error("FAIL %s_timeout: observed=no grant expected=grant within 40 cycles", tag);
        end
        g = gnt;
        c = cyc;
    endtask

    task automatic set_op(input int k, input logic [N-1:0] a, input logic [M-1:0] b);
        a_in[k*N +: N] = a;
        b_in[k*M +: M] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single transaction with ready held high; checks grant, operands,
    // latency and product.
    task automatic do_op(input string tag, input int k, input logic [N-1:0] a,
                         input logic [M-1:0] b, input logic [PW-1:0] exp);
        logic [NREQ-1:0] g;
        int              c;
        set_op(k, a, b);
        req = NREQ'(1) << k;
        wait_gnt(tag, g, c);
        req = '0;
        chk({tag, "_gnt"},   g,     NREQ'(1) << k);
        chk({tag, "_mul_a"}, mul_a, a);
        chk({tag, "_mul_b"}, mul_b, b);
        @(negedge clk);
        chk({tag, "_gnt_pulse"}, gnt, 0);
        repeat (M) @(negedge clk);
        chk({tag, "_not_early"}, rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"},  rsp_data,  exp);
        chk({tag, "_id"},    rsp_id,    k);
        @(negedge clk);
        chk({tag, "_drop"},  rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] g;
        int              c;
        int              c_prev;
        logic            seen;

        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",   gnt,       0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id",    rsp_id,    0);
        chk("rst_data",  rsp_data,  0);
        chk("rst_mul_a", mul_a,     0);
        chk("rst_mul_b", mul_b,     0);
        chk("rst_mulrst",mul_rst,   1);
        rst_n = 1'b1;

        // Single op and corner products
        do_op("t1",  0, 5'h1D, 6'h07, 12'hFEB);
        do_op("c1",  2, 5'h10, 6'h20, 12'h200);
        do_op("c2",  1, 5'h0F, 6'h1F, 12'h1D1);
        do_op("c3",  3, 5'h00, 6'h3F, 12'h000);

        // Backpressure: 5 * -3 = -15
        rsp_ready = 1'b0;
        set_op(1, 5'h05, 6'h3D);
        req = 4'b0010;
        wait_gnt("bp", g, c);
        chk("bp_gnt", g, 4'b0010);
        repeat (M+2) @(negedge clk);
        chk("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data",  rsp_data,  12'hFF1);
            chk("bp_hold_id",    rsp_id,    1);
            chk("bp_hold_gnt",   gnt,       0);
            chk("bp_hold_mrst",  mul_rst,   1);
        end
        req       = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", rsp_valid, 0);

        // Reset in the middle of RUN
        set_op(3, 5'h0B, 6'h05);
        req = 4'b1000;
        wait_gnt("mr", g, c);
        req = '0;
        repeat (3) @(negedge clk);
        chk("mr_inrun_mrst", mul_rst, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_gnt",   gnt,       0);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_id",    rsp_id,    0);
        chk("mr_data",  rsp_data,  0);
        chk("mr_mul_a", mul_a,     0);
        chk("mr_mul_b", mul_b,     0);
        chk("mr_mrst",  mul_rst,   1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", seen, 0);

`ifdef MUL_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 always wins while it requests
        for (int k = 0; k < NREQ; k++) set_op(k, N'(k + 1), M'(k + 2));
        req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            wait_gnt("fp", g, c);
            chk("fp_gnt0", g, 4'b0001);
        end
        req = 4'b1010;
        wait_gnt("fp1", g, c);
        chk("fp_gnt1", g, 4'b0010);
        req = '0;
        repeat (M+4) @(negedge clk);
`else
        // Round-robin with all requesting; pointer starts at NREQ-1
        do_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, N'(k + 1), M'(k + 2));
        req    = 4'b1111;
        c_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr", g, c);
            chk("rr_order", g, NREQ'(1) << (i % NREQ));
            if (i > 0) chk("rr_spacing", c - c_prev, M + 4);
            c_prev = c;
        end
        req = '0;
        repeat (M+4) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
